// File: rtl/lz_early_divider.sv
// Unsigned 32-bit divider that uses the operands' leading-zero counts to skip leading quotient bits.
// Optional `DIV_CYCLE_CNT_EN adds a `cycles` output holding the ITER cycle count of the last result.
module lz_early_divider #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic [DATA_W-1:0] dividend_lz,
  input  logic [DATA_W-1:0] divisor_lz,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
`ifdef DIV_CYCLE_CNT_EN
  ,
  output logic [CNT_W-1:0]  cycles
`endif
);

  // Handshake: start is taken on any edge where the block is not iterating and
  // flush is low; done is a one-cycle pulse; busy marks the ITER cycles.
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] rem, q, d_sh;
  logic [CNT_W-1:0]  cnt;

  logic [CNT_W-1:0]  dz, vz, k;
  logic              div_zero, early_out, accept;
  logic              rem_ge;
  logic [DATA_W-1:0] rem_step, q_step;
  logic              unused_lz;

  assign dz        = dividend_lz[CNT_W-1:0];
  assign vz        = divisor_lz[CNT_W-1:0];
  assign k         = vz - dz;
  assign div_zero  = (vz == CNT_W'(DATA_W));
  assign early_out = div_zero || (vz < dz);
  assign accept    = start && !flush && (state != S_ITER);
  assign unused_lz = ^{dividend_lz[DATA_W-1:CNT_W], divisor_lz[DATA_W-1:CNT_W]};

  assign rem_ge   = (rem >= d_sh);
  assign rem_step = rem_ge ? (rem - d_sh) : rem;
  assign q_step   = rem_ge ? (q | (DATA_W'(1) << cnt)) : q;

  assign busy = (state == S_ITER);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) state_next = early_out ? S_DONE : S_ITER;
          else       state_next = S_IDLE;
        end
        S_ITER:  if (cnt == '0) state_next = S_DONE;
        default: state_next = S_IDLE;
      endcase
    end
  end

`ifdef DIV_CYCLE_CNT_EN
  logic [CNT_W-1:0] k_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rem       <= '0;
      q         <= '0;
      d_sh      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_CYCLE_CNT_EN
      k_reg     <= '0;
      cycles    <= '0;
`endif
    end else if (flush) begin
      // Abort only: results and counters stay as they were.
    end else if (accept) begin
      rem <= dividend;
      q   <= '0;
      if (div_zero) begin
        quotient  <= '1;
        remainder <= dividend;
`ifdef DIV_CYCLE_CNT_EN
        cycles    <= '0;
`endif
      end else if (vz < dz) begin
        quotient  <= '0;
        remainder <= dividend;
`ifdef DIV_CYCLE_CNT_EN
        cycles    <= '0;
`endif
      end else begin
        // k <= vz guarantees no significant divisor bit is shifted out.
        d_sh <= divisor << k;
        cnt  <= k;
`ifdef DIV_CYCLE_CNT_EN
        k_reg <= k;
`endif
      end
    end else if (state == S_ITER) begin
      rem  <= rem_step;
      q    <= q_step;
      d_sh <= d_sh >> 1;
      if (cnt == '0) begin
        quotient  <= q_step;
        remainder <= rem_step;
`ifdef DIV_CYCLE_CNT_EN
        cycles    <= k_reg + CNT_W'(1);
`endif
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lz_early_divider.sv
// Randomized and directed checks of lz_early_divider against an arithmetic divide model.
module tb_lz_early_divider;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [31:0] dividend, divisor, dividend_lz, divisor_lz;
  logic        busy, done;
  logic [31:0] quotient, remainder;
`ifdef DIV_CYCLE_CNT_EN
  logic [5:0]  cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_q = '0, last_r = '0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] lzc(input logic [31:0] v);
    int n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) break;
      n++;
    end
    return 32'(n);
  endfunction

  assign dividend_lz = lzc(dividend);
  assign divisor_lz  = lzc(divisor);

  lz_early_divider dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .dividend(dividend), .divisor(divisor),
    .dividend_lz(dividend_lz), .divisor_lz(divisor_lz),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder)
`ifdef DIV_CYCLE_CNT_EN
    , .cycles(cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Starts a divide in the current cycle (called at a negedge) and follows it to done.
  // poke > 0 re-asserts start with 9/3 in that cycle, which must be ignored.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int poke);
    int dz, vz, lat, cyc, iters;
    logic [63:0] exp;
    logic seen;
    dz = int'(lzc(a));
    vz = int'(lzc(b));
    if (vz == 32 || vz < dz) begin lat = 1; iters = 0; end
    else begin lat = vz - dz + 2; iters = vz - dz + 1; end
    exp_q.push_back((b == 0) ? {32'hFFFF_FFFF, a} : {a / b, a % b});
    dividend = a; divisor = b; start = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
      end else begin
        check("busy_iter", 64'(busy), 64'd1);
        check("hold_q", 64'(quotient), 64'(last_q));
        check("hold_r", 64'(remainder), 64'(last_r));
      end
      start = 1'b0;
      if (!seen && cyc == poke) begin
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(cyc), 64'(lat));
    exp = exp_q.pop_front();
    check("quotient", 64'(quotient), 64'(exp[63:32]));
    check("remainder", 64'(remainder), 64'(exp[31:0]));
    check("busy_done", 64'(busy), 64'd0);
`ifdef DIV_CYCLE_CNT_EN
    check("cycles", 64'(cycles), 64'(iters));
`endif
    last_q = exp[63:32];
    last_r = exp[31:0];
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; flush = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_q", 64'(quotient), 64'd0);
    check("rst_r", 64'(remainder), 64'd0);
    rst = 1'b0;
    idle_cycle();

    run_op(32'd100, 32'd7, 0);
    idle_cycle();
    run_op(32'hFFFF_FFFF, 32'd1, 0);
    idle_cycle();
    run_op(32'd5, 32'd9, 0);
    run_op(32'h1234, 32'd0, 0);

    // Flush in cycle 3 of 100/7, then a fresh start in cycle 4.
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    check("flush_busy_before", 64'(busy), 64'd1);
    @(negedge clk); flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_q", 64'(quotient), 64'(last_q));
    check("flush_r", 64'(remainder), 64'(last_r));
    run_op(32'h2A, 32'd6, 0);

    idle_cycle();
    run_op(32'd100, 32'd7, 2);
    run_op(32'd9, 32'd3, 0);
    idle_cycle();

    // Reset in cycle 3 of a long divide.
    start = 1'b1; dividend = 32'hFFFF_FFFF; divisor = 32'd1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_q", 64'(quotient), 64'd0);
    check("mid_rst_r", 64'(remainder), 64'd0);
`ifdef DIV_CYCLE_CNT_EN
    check("mid_rst_cycles", 64'(cycles), 64'd0);
`endif
    last_q = '0; last_r = '0;
    run_op(32'd0, 32'd0, 0);

    for (int i = 0; i < 150; i++) begin
      int gap;
      a = $urandom >> $urandom_range(0, 31);
      b = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle();
      run_op(a, b, ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    idle_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lz_early_divider.md
Name: lz_early_divider

Overview:
- Multi-cycle unsigned 32-bit divider for the EX stage (DIVU path); sits directly downstream of two lead0_counter instances, one on the dividend and one on the divisor.
- Uses the two leading-zero counts to skip leading quotient bits, so a divide costs (divisor_lz - dividend_lz + 1) iteration cycles instead of a fixed 32.
- Delivers quotient/remainder to HI/LO write logic with a start/busy/done handshake and a pipeline flush.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- CNT_W, 6, width of internal iteration counter and of the leading-zero values used (0..32).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a divide; sampled only when not busy.
- flush  input  1  pipeline flush; aborts any operation in flight.
- dividend  input  32  unsigned dividend.
- divisor  input  32  unsigned divisor.
- dividend_lz  input  32  leading-zero count of dividend from lead0_counter; bits [5:0] used, bits [31:6] ignored, value 0..32.
- divisor_lz  input  32  leading-zero count of divisor; same rules as dividend_lz.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  32  registered quotient.
- remainder  output  32  registered remainder.

Behaviour:
- States:
  - IDLE.
  - ITER.
  - DONE: lasts one cycle, then returns to IDLE unless a new start is accepted.
- busy = (state==ITER); done = (state==DONE).
- Reset: state IDLE; busy=0, done=0, quotient=0, remainder=0, internal registers 0. A reset mid-ITER discards the operation with no done pulse.
- Accept: start is accepted in IDLE or DONE when flush=0. Notation:
  - dz = dividend_lz[5:0], vz = divisor_lz[5:0].
  - On the accept edge the block registers rem = dividend, q = 0.
- Case order on accept, first match wins:
  - (a) vz==32 (divisor zero): go to DONE; quotient = 0xFFFFFFFF, remainder = dividend.
  - (b) vz < dz (divisor > dividend, includes dividend==0): go to DONE; quotient = 0, remainder = dividend.
  - (c) Otherwise: k = vz - dz (0..31); d_sh = divisor << k; cnt = k; go to ITER.
- ITER, each cycle:
  - If rem >= d_sh: rem = rem - d_sh and q[cnt] = 1.
  - Then d_sh = d_sh >> 1.
  - If cnt==0: load quotient/remainder from the final q/rem and go to DONE; else cnt = cnt - 1.
- All compares and subtracts are 32-bit unsigned; d_sh never overflows because k <= vz.
- Latency, with start high in cycle 0:
  - Cases (a)/(b): done in cycle 1.
  - Case (c): ITER in cycles 1..k+1, done in cycle k+2.
- quotient/remainder are updated only on entry to DONE and held until the next DONE; they keep their old values during ITER and after a flush.
- start while busy is ignored (not queued).
- Start in the DONE cycle is accepted: back-to-back operation; done drops, or re-pulses the next cycle for an early-out.
- flush has priority over start. In any state the next state is IDLE, with no done and no result update.

Optional Feature:
- Macro DIV_CYCLE_CNT_EN.
- Defined:
  - Extra output port cycles [5:0], registered, reset 0.
  - Loaded on entry to DONE with the number of ITER cycles of that operation (k+1 for case (c), 0 for cases (a)/(b)).
  - Held otherwise; flush does not update it.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- 100/7 (dz=25, vz=29, k=4) -> busy in cycles 1-5, done in cycle 6, quotient=14, remainder=2, cycles=5.
- 0xFFFFFFFF/1 (dz=0, vz=31) -> done in cycle 33, quotient=0xFFFFFFFF, remainder=0, cycles=32.
- 5/9 (dz=29, vz=28) -> no busy, done in cycle 1, quotient=0, remainder=5; then 0x1234/0 -> done next, quotient=0xFFFFFFFF, remainder=0x1234.
- Start 100/7, assert flush in cycle 3 -> busy=0 in cycle 4, no done pulse, quotient/remainder keep their prior values; a start in cycle 4 with 0x2A/6 is accepted -> quotient=7, remainder=0.
- Start 100/7, pulse start again with 9/3 in cycle 2 -> second start ignored, result 14/2; start 9/3 in the DONE cycle -> accepted back-to-back, quotient=3, remainder=0.
- rst asserted in cycle 3 of 0xFFFFFFFF/1 -> all outputs 0 in the next cycle, no done pulse; after release, 0/0 -> done in cycle 1, quotient=0xFFFFFFFF, remainder=0.
